if_id_queue: RTL and testbench

- Decoupling buffer directly downstream of the instruction-fetch stage.
- Captures each fetched instruction and its PC+4 (next_addr) into a small circular FIFO, and presents the oldest entry to the decode stage.
- Drives the fetch stage's PC write-enable, so fetch stalls only when the queue is full.
- Discards all queued, wrong-path instructions on a taken branch or jump.

---
 rtl/if_id_queue.sv | 106 ++++++++++
 tb/tb_if_id_queue.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/if_id_queue.sv
// if_id_queue: circular decoupling FIFO between instruction fetch and decode.
// Holds {inst, next_addr} pairs. It presents the oldest entry to decode and
// stalls fetch only when every slot is occupied. A redirect discards all
// queued wrong-path entries.
module if_id_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         if_inst,
  input  logic [31:0]         if_next_addr,
  input  logic                flush,
  input  logic                id_stall,
  output logic                pc_write,
  output logic                id_valid,
  output logic [31:0]         id_inst,
  output logic [31:0]         id_next_addr,
  output logic [PTR_W:0]      count
);

  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] next_addr;
  } entry_t;

  entry_t             mem [DEPTH];
  entry_t             in_entry;
  entry_t             head_nxt;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr_nxt;
  logic [PTR_W-1:0]   rd_ptr_nxt;
  logic [CNT_W-1:0]   count_nxt;
  logic               enq;
  logic               deq;

  // Transfer qualifiers; pc_write and id_valid are registered decodes of count.
  always_comb begin
    in_entry = '{inst: if_inst, next_addr: if_next_addr};
    enq      = pc_write & ~flush;
    deq      = id_valid & ~id_stall & ~flush;
  end

  // Next pointer/occupancy state; a flush overrides every other event.
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count;
    if (flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      count_nxt  = '0;
    end else begin
      if (enq) wr_ptr_nxt = wr_ptr + PTR_W'(1);
      if (deq) rd_ptr_nxt = rd_ptr + PTR_W'(1);
      unique case ({enq, deq})
        2'b10:   count_nxt = count + CNT_W'(1);
        2'b01:   count_nxt = count - CNT_W'(1);
        default: count_nxt = count;
      endcase
    end
  end

  // Next head entry: the slot written this edge when it becomes the head, else storage.
  always_comb begin
    head_nxt = '0;
    if (count_nxt != '0) begin
      if (enq && (wr_ptr == rd_ptr_nxt)) begin
        head_nxt = in_entry;
      end else begin
        head_nxt = mem[rd_ptr_nxt];
      end
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= in_entry;
  end

  // Pointers, occupancy and registered decode-side outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      pc_write     <= 1'b1;
      id_valid     <= 1'b0;
      id_inst      <= '0;
      id_next_addr <= '0;
    end else begin
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      count        <= count_nxt;
      pc_write     <= (count_nxt != FULL_CNT);
      id_valid     <= (count_nxt != '0);
      id_inst      <= head_nxt.inst;
      id_next_addr <= head_nxt.next_addr;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: constant vector table, directed corner sequences and
// random traffic compared against a queue-based reference model.
module tb_if_id_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PTR_W = 2;

  logic        clk;
  logic        rst;
  logic [31:0] if_inst;
  logic [31:0] if_next_addr;
  logic        flush;
  logic        id_stall;
  logic        pc_write;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_next_addr;
  logic [PTR_W:0] count;

  int n_pass  = 0;
  int n_total = 0;

  logic [63:0] q [$];

  if_id_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst(rst), .if_inst(if_inst), .if_next_addr(if_next_addr),
    .flush(flush), .id_stall(id_stall), .pc_write(pc_write), .id_valid(id_valid),
    .id_inst(id_inst), .id_next_addr(id_next_addr), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] na;
    logic        fl;
    logic        st;
    int          e_count;
    logic        e_pcw;
    logic [31:0] e_inst;
    logic [31:0] e_na;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  task automatic check_model();
    logic [63:0] head;
    head = (q.size() != 0) ? q[0] : 64'h0;
    chk("model_count", 64'(count), 64'(q.size()));
    chk("model_pc_write", 64'(pc_write), 64'(q.size() != DEPTH));
    chk("model_id_valid", 64'(id_valid), 64'(q.size() != 0));
    chk("model_id_inst", 64'(id_inst), 64'(head[63:32]));
    chk("model_id_next_addr", 64'(id_next_addr), 64'(head[31:0]));
  endtask

  // One clock: drive at negedge, update model at posedge, check at next negedge.
  task automatic cycle(input logic [31:0] i, input logic [31:0] na, input logic fl, input logic st);
    bit m_enq, m_deq;
    if_inst = i; if_next_addr = na; flush = fl; id_stall = st;
    @(posedge clk);
    m_enq = (q.size() != DEPTH) && !fl;
    m_deq = (q.size() != 0) && !st && !fl;
    if (fl) q.delete();
    else begin
      if (m_deq) void'(q.pop_front());
      if (m_enq) q.push_back({i, na});
    end
    @(negedge clk);
    check_model();
  endtask

  vec_t tbl [11];

  initial begin
    rst = 1'b0; if_inst = '0; if_next_addr = '0; flush = 1'b0; id_stall = 1'b0;

    tbl[0]  = '{32'hA0000001, 32'h104, 0, 1, 1, 1, 32'hA0000001, 32'h104};
    tbl[1]  = '{32'hB0000002, 32'h108, 0, 1, 2, 1, 32'hA0000001, 32'h104};
    tbl[2]  = '{32'hC0000003, 32'h10C, 0, 1, 3, 1, 32'hA0000001, 32'h104};
    tbl[3]  = '{32'hD0000004, 32'h110, 0, 1, 4, 0, 32'hA0000001, 32'h104};
    tbl[4]  = '{32'hE0000005, 32'h114, 0, 1, 4, 0, 32'hA0000001, 32'h104};
    tbl[5]  = '{32'hE0000005, 32'h114, 0, 0, 3, 1, 32'hB0000002, 32'h108};
    tbl[6]  = '{32'hF0000006, 32'h118, 0, 0, 3, 1, 32'hC0000003, 32'h10C};
    tbl[7]  = '{32'h70000007, 32'h11C, 0, 0, 3, 1, 32'hD0000004, 32'h110};
    tbl[8]  = '{32'h80000008, 32'h120, 0, 0, 3, 1, 32'hF0000006, 32'h118};
    tbl[9]  = '{32'h1000FFFF, 32'h124, 1, 0, 0, 1, 32'h0, 32'h0};
    tbl[10] = '{32'h90000009, 32'h200, 0, 0, 1, 1, 32'h90000009, 32'h200};

    // Reset held for two cycles, then released.
    repeat (2) @(negedge clk);
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_pc_write", 64'(pc_write), 64'd1);
    chk("reset_id_valid", 64'(id_valid), 64'd0);
    chk("reset_id_inst", 64'(id_inst), 64'd0);
    rst = 1'b1;

    // Fill to full under stall, drain, flush with entries queued.
    for (int k = 0; k < 11; k++) begin
      cycle(tbl[k].inst, tbl[k].na, tbl[k].fl, tbl[k].st);
      chk($sformatf("tbl%0d_count", k), 64'(count), 64'(tbl[k].e_count));
      chk($sformatf("tbl%0d_pc_write", k), 64'(pc_write), 64'(tbl[k].e_pcw));
      chk($sformatf("tbl%0d_id_valid", k), 64'(id_valid), 64'(tbl[k].e_count != 0));
      chk($sformatf("tbl%0d_id_inst", k), 64'(id_inst), 64'(tbl[k].e_inst));
      chk($sformatf("tbl%0d_id_next_addr", k), 64'(id_next_addr), 64'(tbl[k].e_na));
    end

    // Free-run from empty: occupancy holds at 1, one-cycle latency.
    cycle(32'h0, 32'h0, 1'b1, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      cycle(32'h20080000 + 32'(k), 32'(4 * k), 1'b0, 1'b0);
      chk("free_count", 64'(count), 64'd1);
      chk("free_pc_write", 64'(pc_write), 64'd1);
      chk("free_id_inst", 64'(id_inst), 64'(32'h20080000 + 32'(k)));
    end

    // Hold occupancy at 2 with simultaneous enq/deq across pointer wrap.
    cycle(32'h30000000, 32'h300, 1'b0, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      cycle(32'h30000000 + 32'(k), 32'h300 + 32'(4 * k), 1'b0, 1'b0);
      chk("wrap_count", 64'(count), 64'd2);
      chk("wrap_id_inst", 64'(id_inst), 64'(32'h30000000 + 32'(k - 1)));
    end

    // Flush while stalled and full.
    cycle(32'h40000001, 32'h400, 1'b0, 1'b1);
    cycle(32'h40000002, 32'h404, 1'b0, 1'b1);
    chk("full_count", 64'(count), 64'd4);
    chk("full_pc_write", 64'(pc_write), 64'd0);
    cycle(32'h4000FFFF, 32'h408, 1'b1, 1'b1);
    chk("fullflush_count", 64'(count), 64'd0);
    chk("fullflush_pc_write", 64'(pc_write), 64'd1);
    chk("fullflush_id_inst", 64'(id_inst), 64'd0);

    // Asynchronous reset between edges with three entries queued.
    for (int k = 0; k < 3; k++) cycle(32'h50000000 + 32'(k), 32'h500, 1'b0, 1'b1);
    chk("pre_areset_count", 64'(count), 64'd3);
    #2 rst = 1'b0;
    #1;
    chk("areset_count", 64'(count), 64'd0);
    chk("areset_id_valid", 64'(id_valid), 64'd0);
    chk("areset_id_inst", 64'(id_inst), 64'd0);
    chk("areset_pc_write", 64'(pc_write), 64'd1);
    q.delete();
    @(negedge clk);
    rst = 1'b1;
    check_model();

    // Random traffic against the reference model.
    for (int k = 0; k < 400; k++) begin
      cycle($urandom, $urandom, $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 4);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
